fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter IMEM_AW, default 7, byte-address width presented to instruction memory.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port stall, input, 1, hold PC and IF/ID contents.
REQ-006 SHALL have port flush, input, 1, replace IF/ID contents with bubble.
REQ-007 SHALL have port jump, input, 1, take jump redirect this cycle.
REQ-008 SHALL have port jump_index, input, 26, J-format target field.
REQ-009 SHALL have port branch_taken, input, 1, take branch redirect this cycle.
REQ-010 SHALL have port branch_target, input, 32, branch destination byte address.
REQ-011 SHALL have port imem_addr, output, IMEM_AW, byte address to instruction memory = pc[IMEM_AW-1:0].
REQ-012 SHALL have port imem_instr, input, 32, combinational instruction word returned for imem_addr.
REQ-013 SHALL have port pc, output, 32, current fetch PC.
REQ-014 SHALL have port ifid_instr, output, 32, registered instruction to decode.
REQ-015 SHALL have port ifid_pc4, output, 32, registered PC+4 of that instruction.
REQ-016 SHALL have port ifid_valid, output, 1, IF/ID holds a real instruction.
REQ-017 SHALL have port misalign_err, output, 1, sticky misaligned-redirect flag (see Configuration).

Function
REQ-018 SHALL compute pc4 = pc + 32'd4, modulo 2^32 (wrap 0xFFFF_FFFC -> 0).
REQ-019 SHALL select next PC by priority: jump -> {pc4[31:28], jump_index, 2'b00}; else branch_taken -> branch_target; else stall -> pc; else pc4.
REQ-020 SHALL let a redirect (jump or branch_taken) update PC even when stall is high.
REQ-021 SHALL, on each non-stalled, non-flushed edge, load ifid_instr<=imem_instr, ifid_pc4<=pc4, ifid_valid<=1 (fetch-to-IF/ID latency one cycle).
REQ-022 SHALL, when flush is high, load ifid_instr<=32'h0 (NOP), ifid_pc4<=0, ifid_valid<=0, regardless of stall.
REQ-023 SHALL, when stall high and flush low, hold all IF/ID outputs unchanged.
REQ-024 SHALL drive imem_addr from pc truncated to IMEM_AW bits; addresses beyond memory wrap silently.
REQ-025 SHALL NOT auto-flush on redirect; flush is supplied by the hazard logic.

Reset
REQ-026 SHALL asynchronously on rst_n low set pc=RESET_PC, ifid_instr=0, ifid_pc4=0, ifid_valid=0, misalign_err=0.
REQ-027 SHALL, on rst_n deassertion, fetch from RESET_PC on the first rising edge; reset mid-stall or mid-redirect discards pending state.

Configuration
REQ-028 SHALL, with FETCH_ALIGN_CHECK_EN defined, set misalign_err sticky (cleared only by reset) when a taken branch_target has bits[1:0]!=0, and force the loaded PC bits[1:0] to 2'b00.
REQ-029 SHALL, without FETCH_ALIGN_CHECK_EN, tie misalign_err to 0 and load branch_target unmodified.

Structure
REQ-030 SHALL place NOP constant (32'h0), instruction width (32), J-index width (26) and PC increment (4) in shared package fetch_pkg.
REQ-031 SHALL implement the IF/ID register as sub-module if_id_reg (stall/flush/valid handling); PC logic stays in fetch_unit.

Verification
REQ-032 SHALL test reset release with memory word 0 = 32'h20080001 -> pc 0,4,8; after first edge ifid_instr=32'h20080001, ifid_pc4=4, ifid_valid=1.
REQ-033 SHALL test jump=1, jump_index=26'h3 at pc=0x10 -> next pc=0x0C, imem_addr=7'h0C.
REQ-034 SHALL test stall=1 for 3 cycles at pc=0x08 -> pc and IF/ID unchanged; stall=1 with branch_taken=1, branch_target=0x20 -> pc=0x20.
REQ-035 SHALL test stall=1 and flush=1 together -> ifid_instr=0, ifid_valid=0, pc held.
REQ-036 SHALL test branch_target=0x22 with FETCH_ALIGN_CHECK_EN -> pc=0x20, misalign_err=1 held until rst_n low; without macro -> pc=0x22, misalign_err=0.
REQ-037 SHALL test pc=0x7C -> imem_addr=7'h7C, next imem_addr=7'h00 while pc=0x80.

Source files
------------

// File: rtl/fetch_pkg.sv
// ==========================================================================
// fetch_pkg : shared constants and types for the instruction fetch stage
// Revision  : 1.0
// ==========================================================================
`default_nettype none

package fetch_pkg;

   localparam int          INSTR_W = 32;
   localparam int          JIDX_W  = 26;
   localparam logic [31:0] NOP     = 32'h0000_0000;
   localparam logic [31:0] PC_INC  = 32'd4;

   typedef enum logic [1:0] {
      SRC_SEQ    = 2'd0,
      SRC_HOLD   = 2'd1,
      SRC_BRANCH = 2'd2,
      SRC_JUMP   = 2'd3
   } pc_src_e;

   // Redirects win over stall so that a taken control transfer is never lost.
   function automatic pc_src_e select_src(input logic jump, input logic branch_taken,
                                          input logic stall);
      if (jump)              return SRC_JUMP;
      else if (branch_taken) return SRC_BRANCH;
      else if (stall)        return SRC_HOLD;
      else                   return SRC_SEQ;
   endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if_id_reg.sv
// ==========================================================================
// if_id_reg : IF/ID pipeline register with stall hold and flush-to-bubble
// Revision  : 1.0
// ==========================================================================
`default_nettype none

module if_id_reg
   import fetch_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               flush,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic [31:0]        pc4_in,
   output logic [INSTR_W-1:0] instr,
   output logic [31:0]        pc4,
   output logic               valid
);

   // Flush dominates stall: a squashed slot must never be held as live.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr <= NOP;
         pc4   <= 32'h0;
         valid <= 1'b0;
      end else if (flush) begin
         instr <= NOP;
         pc4   <= 32'h0;
         valid <= 1'b0;
      end else if (!stall) begin
         instr <= instr_in;
         pc4   <= pc4_in;
         valid <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ==========================================================================
// fetch_unit : PC sequencing (jump/branch/stall) feeding the IF/ID register
//              Optional misaligned-branch check: define FETCH_ALIGN_CHECK_EN
// Revision   : 1.0
// ==========================================================================
`default_nettype none

module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IMEM_AW  = 7
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               stall,
   input  logic               flush,
   input  logic               jump,
   input  logic [JIDX_W-1:0]  jump_index,
   input  logic               branch_taken,
   input  logic [31:0]        branch_target,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [INSTR_W-1:0] imem_instr,
   output logic [31:0]        pc,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [31:0]        ifid_pc4,
   output logic               ifid_valid,
   output logic               misalign_err
);

   logic [31:0] pc4;
   logic [31:0] br_tgt;
   logic [31:0] next_pc;
   pc_src_e     src;

   assign pc4       = pc + PC_INC;
   assign imem_addr = pc[IMEM_AW-1:0];
   assign src       = select_src(jump, branch_taken, stall);

`ifdef FETCH_ALIGN_CHECK_EN
   logic misalign_hit;

   assign br_tgt       = {branch_target[31:2], 2'b00};
   assign misalign_hit = (src == SRC_BRANCH) && (branch_target[1:0] != 2'b00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            misalign_err <= 1'b0;
      else if (misalign_hit) misalign_err <= 1'b1;
   end
`else
   assign br_tgt       = branch_target;
   assign misalign_err = 1'b0;
`endif

   always_comb begin
      next_pc = pc4;
      unique case (src)
         SRC_JUMP:   next_pc = {pc4[31:28], jump_index, 2'b00};
         SRC_BRANCH: next_pc = br_tgt;
         SRC_HOLD:   next_pc = pc;
         SRC_SEQ:    next_pc = pc4;
         default:    next_pc = pc4;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc <= RESET_PC;
      else        pc <= next_pc;
   end

   if_id_reg u_if_id (
      .clk      (clk),
      .rst_n    (rst_n),
      .stall    (stall),
      .flush    (flush),
      .instr_in (imem_instr),
      .pc4_in   (pc4),
      .instr    (ifid_instr),
      .pc4      (ifid_pc4),
      .valid    (ifid_valid)
   );

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ==========================================================================
// tb_fetch_unit : directed + randomized bench with a behavioural fetch model
// Revision      : 1.0
// ==========================================================================
`default_nettype none

module tb_fetch_unit;

`ifdef FETCH_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0, flush = 1'b0, jump = 1'b0, branch_taken = 1'b0;
   logic [25:0] jump_index = '0;
   logic [31:0] branch_target = '0;
   logic [6:0]  imem_addr;
   logic [31:0] imem_instr, pc, ifid_instr, ifid_pc4;
   logic        ifid_valid, misalign_err;

   logic [31:0] mem [32];

   int checks = 0;
   int passes = 0;

   // behavioural model state
   logic [31:0] m_pc = 32'h0, m_instr = 32'h0, m_pc4 = 32'h0;
   logic        m_valid = 1'b0, m_err = 1'b0;

   always #5 clk = ~clk;

   assign imem_instr = mem[imem_addr[6:2]];

   fetch_unit #(.RESET_PC(32'h0), .IMEM_AW(7)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .jump(jump),
      .jump_index(jump_index), .branch_taken(branch_taken), .branch_target(branch_target),
      .imem_addr(imem_addr), .imem_instr(imem_instr), .pc(pc), .ifid_instr(ifid_instr),
      .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid), .misalign_err(misalign_err)
   );

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_err = 1'b0;
      end else begin
         logic [31:0] seq;
         seq = m_pc + 32'd4;
         if (flush) begin
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
         end else if (!stall) begin
            m_instr = mem[m_pc[6:2]]; m_pc4 = seq; m_valid = 1'b1;
         end
         if (jump)
            m_pc = {seq[31:28], jump_index, 2'b00};
         else if (branch_taken) begin
            if (ALIGN && branch_target[1:0] != 2'b00) begin
               m_err = 1'b1;
               m_pc  = branch_target & 32'hFFFF_FFFC;
            end else
               m_pc = branch_target;
         end else if (!stall)
            m_pc = seq;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   always @(negedge clk) begin
      check("model_pc", pc, m_pc);
      check("model_imem_addr", {25'h0, imem_addr}, {25'h0, m_pc[6:0]});
      check("model_ifid_instr", ifid_instr, m_instr);
      check("model_ifid_pc4", ifid_pc4, m_pc4);
      check("model_ifid_valid", {31'h0, ifid_valid}, {31'h0, m_valid});
      check("model_misalign", {31'h0, misalign_err}, {31'h0, m_err});
   end

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      mem[0] = 32'h2008_0001;

      // reset state
      repeat (2) @(negedge clk);
      check("rst_pc", pc, 32'h0);
      check("rst_ifid_instr", ifid_instr, 32'h0);
      check("rst_ifid_valid", {31'h0, ifid_valid}, 32'h0);
      check("rst_err", {31'h0, misalign_err}, 32'h0);
      rst_n = 1'b1;

      @(negedge clk);
      check("rel_pc4", pc, 32'h4);
      check("rel_ifid_instr", ifid_instr, 32'h2008_0001);
      check("rel_ifid_pc4", ifid_pc4, 32'h4);
      check("rel_ifid_valid", {31'h0, ifid_valid}, 32'h1);
      @(negedge clk);
      check("rel_pc8", pc, 32'h8);

      // stall for three cycles
      stall = 1'b1;
      repeat (3) @(negedge clk);
      check("stall_pc", pc, 32'h8);
      check("stall_ifid_pc4", ifid_pc4, 32'h8);
      check("stall_ifid_instr", ifid_instr, mem[1]);
      branch_taken = 1'b1; branch_target = 32'h20;
      @(negedge clk);
      check("stall_branch_pc", pc, 32'h20);
      check("stall_branch_ifid_pc4", ifid_pc4, 32'h8);
      stall = 1'b0; branch_target = 32'h10;
      @(negedge clk);
      check("branch_pc", pc, 32'h10);

      // jump from 0x10
      branch_taken = 1'b0; jump = 1'b1; jump_index = 26'h3;
      @(negedge clk);
      check("jump_pc", pc, 32'h0C);
      check("jump_imem_addr", {25'h0, imem_addr}, 32'h0C);
      check("jump_ifid_pc4", ifid_pc4, 32'h14);
      jump = 1'b0;

      // stall and flush together
      stall = 1'b1; flush = 1'b1;
      @(negedge clk);
      check("sf_pc", pc, 32'h0C);
      check("sf_ifid_instr", ifid_instr, 32'h0);
      check("sf_ifid_valid", {31'h0, ifid_valid}, 32'h0);
      stall = 1'b0; flush = 1'b0;

      // misaligned branch target
      branch_taken = 1'b1; branch_target = 32'h22;
      @(negedge clk);
      check("mis_pc", pc, ALIGN ? 32'h20 : 32'h22);
      check("mis_err", {31'h0, misalign_err}, ALIGN ? 32'h1 : 32'h0);
      branch_taken = 1'b0;
      repeat (3) @(negedge clk);
      check("mis_err_sticky", {31'h0, misalign_err}, ALIGN ? 32'h1 : 32'h0);

      // imem address wrap
      branch_taken = 1'b1; branch_target = 32'h7C;
      @(negedge clk);
      check("wrap_addr_7c", {25'h0, imem_addr}, 32'h7C);
      branch_taken = 1'b0;
      @(negedge clk);
      check("wrap_pc_80", pc, 32'h80);
      check("wrap_addr_00", {25'h0, imem_addr}, 32'h0);

      // 32-bit PC wrap
      branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
      @(negedge clk);
      branch_taken = 1'b0;
      @(negedge clk);
      check("pc_wrap", pc, 32'h0);
      check("pc_wrap_ifid_pc4", ifid_pc4, 32'h0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         stall         = ($urandom % 4) == 0;
         flush         = ($urandom % 8) == 0;
         jump          = ($urandom % 10) == 0;
         jump_index    = 26'($urandom);
         branch_taken  = ($urandom % 6) == 0;
         branch_target = $urandom;
         if (($urandom % 8) != 0) branch_target[1:0] = 2'b00;
         @(negedge clk);
      end

      // reset mid-stall, mid-redirect
      stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_pc", pc, 32'h0);
      check("async_rst_valid", {31'h0, ifid_valid}, 32'h0);
      check("async_rst_err", {31'h0, misalign_err}, 32'h0);
      @(negedge clk);
      stall = 1'b0; branch_taken = 1'b0; flush = 1'b0; jump = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check("rerel_pc", pc, 32'h4);
      check("rerel_ifid_instr", ifid_instr, 32'h2008_0001);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

`default_nettype wire
